// File: rtl/jk_reg_bank_if.sv
// Bus interface for jk_reg_bank: control/data inputs and state outputs.
// The master drives controls and observes state; the slave is the register bank.
interface jk_reg_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s_n;
  logic [WIDTH-1:0] c_n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;
  logic [WIDTH-1:0] chg;

  modport master (
    output en, mode, s_n, c_n, j, k,
    input  q, qn, tc, chg
  );

  modport slave (
    input  en, mode, s_n, c_n, j, k,
    output q, qn, tc, chg
  );
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-channel synchronous JK flip-flop bank with per-channel
// active-low preset/clear (74HC112 semantics when both are low) and a shared
// mode select: independent JK, binary up-count, shift-left, hold.
// Optional feature macro: JK_REG_BANK_CHG_EN builds registered per-channel
// change flags; without it chg is tied low and no flops are added.
module jk_reg_bank #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         r,
  jk_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_both;
  logic [WIDTH-1:0] w_act;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_both_next;
  mode_e            w_mode;

  assign w_mode = mode_e'(bus.mode);

  // Mode action computed from pre-edge q for every channel; overrides applied afterwards
  always_comb begin
    w_act = r_q;
    if (bus.en) begin
      unique case (w_mode)
        MODE_JK: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({bus.j[i], bus.k[i]})
              2'b01:   w_act[i] = 1'b0;
              2'b10:   w_act[i] = 1'b1;
              2'b11:   w_act[i] = ~r_q[i];
              default: w_act[i] = r_q[i];
            endcase
          end
        end
        MODE_COUNT: w_act = r_q + {{(WIDTH-1){1'b0}}, 1'b1};
        MODE_SHIFT: w_act = {r_q[WIDTH-2:0], bus.j[0]};
        MODE_HOLD:  w_act = r_q;
      endcase
    end
  end

  // Preset wins (also when both are low), then clear, then the mode action
  always_comb begin
    w_q_next    = (w_act & bus.c_n) | ~bus.s_n;
    w_both_next = ~bus.s_n & ~bus.c_n;
  end

  // State and both-flag registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!r) begin
      r_q    <= RESET_VAL;
      r_both <= '0;
    end else begin
      r_q    <= w_q_next;
      r_both <= w_both_next;
    end
  end

  assign bus.q  = r_q;
  assign bus.qn = ~r_q | r_both;
  assign bus.tc = (w_mode == MODE_COUNT) & bus.en & (&r_q) & r & (&bus.s_n) & (&bus.c_n);

`ifdef JK_REG_BANK_CHG_EN
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] w_qn_next;

  assign w_qn_next = ~w_q_next | w_both_next;

  // Flag any q or qn transition for one cycle; reset edges never flag
  always_ff @(posedge clk) begin
    if (!r) begin
      r_chg <= '0;
    end else begin
      r_chg <= (w_q_next ^ r_q) | (w_qn_next ^ bus.qn);
    end
  end

  assign bus.chg = r_chg;
`else
  assign bus.chg = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=4, RESET_VAL=4'b1010): directed
// vectors with literal expectations plus a per-cycle behavioural model compare.
module tb_jk_reg_bank;
  localparam int unsigned W = 4;
  localparam logic [3:0]  RV = 4'b1010;

  logic clk = 1'b0;
  logic r;
  int   checks = 0;
  int   failures = 0;

  jk_reg_bank_if #(.WIDTH(W)) bus ();

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[3:0], exp[3:0], $time);
    end
  endtask

  // Behavioural model: state as integers, updated from the rules on each edge
  int m_q = 0;
  int m_both = 0;
  int m_chg = 0;
  bit m_valid = 1'b0;

  function automatic int m_qn(input int q, input int both);
    return ((~q) | both) & 15;
  endfunction

  always @(posedge clk) begin
    int act, nq, nboth;
    if (!r) begin
      m_q = RV; m_both = 0; m_chg = 0; m_valid = 1'b1;
    end else begin
      act = m_q;
      if (bus.en) begin
        case (bus.mode)
          2'd0: for (int i = 0; i < 4; i++) begin
                  if (bus.j[i] && bus.k[i]) act = act ^ (1 << i);
                  else if (bus.j[i])        act = act | (1 << i);
                  else if (bus.k[i])        act = act & ~(1 << i);
                end
          2'd1: act = (m_q + 1) % 16;
          2'd2: act = (m_q * 2 + int'(bus.j[0])) % 16;
          default: act = m_q;
        endcase
      end
      nq = 0; nboth = 0;
      for (int i = 0; i < 4; i++) begin
        if (!bus.s_n[i]) nq += (1 << i);
        else if (bus.c_n[i]) nq += act & (1 << i);
        if (!bus.s_n[i] && !bus.c_n[i]) nboth += (1 << i);
      end
`ifdef JK_REG_BANK_CHG_EN
      m_chg = (nq ^ m_q) | (m_qn(nq, nboth) ^ m_qn(m_q, m_both));
`else
      m_chg = 0;
`endif
      m_q = nq; m_both = nboth;
    end
  end

  // Per-cycle compare against the model on the falling edge
  always @(negedge clk) begin
    int exp_tc;
    if (m_valid) begin
      exp_tc = (bus.mode == 2'd1 && bus.en && m_q == 15 && r &&
                bus.s_n == 4'hF && bus.c_n == 4'hF) ? 1 : 0;
      check("model_q",   int'(bus.q),   m_q);
      check("model_qn",  int'(bus.qn),  m_qn(m_q, m_both));
      check("model_tc",  int'(bus.tc),  exp_tc);
      check("model_chg", int'(bus.chg), m_chg);
    end
  end

  task automatic step(input logic ri, input logic ei, input logic [1:0] mi,
                      input logic [3:0] si, input logic [3:0] ci,
                      input logic [3:0] ji, input logic [3:0] ki);
    r = ri; bus.en = ei; bus.mode = mi;
    bus.s_n = si; bus.c_n = ci; bus.j = ji; bus.k = ki;
    @(posedge clk);
    #1;
  endtask

  int exp_chg_tog;

  initial begin
`ifdef JK_REG_BANK_CHG_EN
    exp_chg_tog = 4'b0001;
`else
    exp_chg_tog = 4'b0000;
`endif
    // Reset for two edges while count mode is requested
    step(1'b0, 1'b1, 2'b01, 4'hF, 4'hF, 4'h0, 4'h0);
    step(1'b0, 1'b1, 2'b01, 4'hF, 4'hF, 4'h0, 4'h0);
    check("reset_q",   int'(bus.q),   4'b1010);
    check("reset_qn",  int'(bus.qn),  4'b0101);
    check("reset_tc",  int'(bus.tc),  0);
    check("reset_chg", int'(bus.chg), 0);

    // Clear all channels to reach 0000
    step(1'b1, 1'b0, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0);
    check("clear_q", int'(bus.q), 4'b0000);

    // JK: ch3 toggle, ch2 set, ch1 clear, ch0 hold
    step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 4'b1100, 4'b1010);
    check("jk_edge1", int'(bus.q), 4'b1100);
    step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 4'b1100, 4'b1010);
    check("jk_edge2", int'(bus.q), 4'b0100);
    step(1'b1, 1'b0, 2'b00, 4'hF, 4'hF, 4'b1100, 4'b1010);
    check("jk_en0", int'(bus.q), 4'b0100);

    // Load 1110 via preset ch3..1 and clear ch0
    step(1'b1, 1'b0, 2'b00, 4'b0001, 4'b1110, 4'h0, 4'h0);
    check("load_1110", int'(bus.q), 4'b1110);

    // Count to all ones, terminal count, wrap
    step(1'b1, 1'b1, 2'b01, 4'hF, 4'hF, 4'h0, 4'h0);
    check("cnt_1111", int'(bus.q), 4'b1111);
    check("cnt_tc1",  int'(bus.tc), 1);
    bus.c_n = 4'b1110;
    #1;
    check("tc_gated_by_clear", int'(bus.tc), 0);
    step(1'b1, 1'b1, 2'b01, 4'hF, 4'hF, 4'h0, 4'h0);
    check("cnt_wrap", int'(bus.q), 4'b0000);
    check("cnt_tc0",  int'(bus.tc), 0);
    step(1'b1, 1'b1, 2'b01, 4'hF, 4'b1110, 4'h0, 4'h0);
    check("cnt_clear_ch0", int'(bus.q), 4'b0000);

    // Preset and clear both low on ch2, then release in hold
    step(1'b1, 1'b1, 2'b11, 4'b1011, 4'b1011, 4'h0, 4'h0);
    check("both_q",  int'(bus.q),  4'b0100);
    check("both_qn", int'(bus.qn), 4'b1111);
    step(1'b1, 1'b1, 2'b11, 4'hF, 4'hF, 4'h0, 4'h0);
    check("release_q",  int'(bus.q),  4'b0100);
    check("release_qn", int'(bus.qn), 4'b1011);

    // Load 0001, then shift in 1,0,1
    step(1'b1, 1'b0, 2'b00, 4'b1110, 4'b0001, 4'h0, 4'h0);
    check("load_0001", int'(bus.q), 4'b0001);
    step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 4'b0001, 4'h0);
    check("shift1", int'(bus.q), 4'b0011);
    step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 4'b0000, 4'h0);
    check("shift2", int'(bus.q), 4'b0110);
    step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 4'b0001, 4'h0);
    check("shift3", int'(bus.q), 4'b1101);
    step(1'b0, 1'b1, 2'b10, 4'hF, 4'hF, 4'b0001, 4'h0);
    check("shift_reset", int'(bus.q), 4'b1010);

    // Change flag: toggle ch0, then hold
    step(1'b1, 1'b1, 2'b00, 4'hF, 4'hF, 4'b0001, 4'b0001);
    check("tog_q",   int'(bus.q),   4'b1011);
    check("tog_chg", int'(bus.chg), exp_chg_tog);
    step(1'b1, 1'b1, 2'b11, 4'hF, 4'hF, 4'h0, 4'h0);
    check("hold_q",   int'(bus.q),   4'b1011);
    check("hold_chg", int'(bus.chg), 4'b0000);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
